// File: rtl/digit_entry_ctrl_pkg.sv
// Shared types and constants for the hex digit entry controller:
// FSM encoding, reset cursor and per-digit place values.
package digit_entry_ctrl_pkg;

  typedef enum logic {
    ST_EDIT   = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

  localparam logic [3:0]  CURSOR_RESET = 4'b0001;

  localparam logic [15:0] PLACE_0 = 16'h0001;
  localparam logic [15:0] PLACE_1 = 16'h0010;
  localparam logic [15:0] PLACE_2 = 16'h0100;
  localparam logic [15:0] PLACE_3 = 16'h1000;

  // Expands a place value into a mask covering its whole nibble.
  function automatic logic [15:0] nibble_mask(input logic [15:0] place);
    return place | (place << 1) | (place << 2) | (place << 3);
  endfunction

endpackage

// File: rtl/digit_entry_ctrl_cursor_place_decode.sv
// Maps the one-hot cursor to the place value of the selected digit;
// any non-one-hot cursor decodes to zero.
module cursor_place_decode
  import digit_entry_ctrl_pkg::*;
(
  input  logic [3:0]  cursor,
  output logic [15:0] place
);

  always_comb begin
    place = '0;
    case (cursor)
      4'b0001: place = PLACE_0;
      4'b0010: place = PLACE_1;
      4'b0100: place = PLACE_2;
      4'b1000: place = PLACE_3;
      default: place = '0;
    endcase
  end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Four-digit hex entry controller with edge-detected buttons, auto-repeat
// and a valid/ready commit port. Define DIGIT_CARRY_EN for full 16-bit carry.
module digit_entry_ctrl
  import digit_entry_ctrl_pkg::*;
#(
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        btnLeft,
  input  logic        btnRight,
  input  logic        btnUp,
  input  logic        btnDown,
  input  logic        btnEnter,
  output logic [3:0]  cursor,
  output logic [15:0] editValue,
  output logic [15:0] outValue,
  output logic        outValid,
  input  logic        outReady,
  output state_e      dbg_state
);

  localparam int CW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REPEAT_CYCLES - 1);

  // Output handshake: outValue is stable while outValid=1; a transfer
  // happens on any rising edge with outValid && outReady.

  state_e         state_q, state_d;
  logic [4:0]     prev_q, prev_d;
  logic [3:0]     cursor_q, cursor_d;
  logic [15:0]    edit_q, edit_d;
  logic [15:0]    out_q, out_d;
  logic           valid_q, valid_d;
  logic [CW-1:0]  rpt_cnt_q, rpt_cnt_d;

  logic [4:0]     btn_lvl;
  logic [4:0]     press;
  logic [15:0]    place;
  logic           cursor_ok;
  logic           held_up, held_dn;
  logic           step_up, step_dn;
  logic [15:0]    step_raw;

  // Bit order doubles as action priority: Enter, Up, Down, Left, Right.
  assign btn_lvl   = {btnEnter, btnUp, btnDown, btnLeft, btnRight};
  assign press     = btn_lvl & ~prev_q;
  assign held_up   = btnUp & prev_q[3];
  assign held_dn   = btnDown & prev_q[2];
  assign cursor_ok = (place != 16'h0000);

  cursor_place_decode u_place (
    .cursor (cursor_q),
    .place  (place)
  );

  always_comb begin
    state_d   = state_q;
    prev_d    = btn_lvl;
    cursor_d  = cursor_q;
    edit_d    = edit_q;
    out_d     = out_q;
    valid_d   = valid_q;
    rpt_cnt_d = '0;
    step_up   = 1'b0;
    step_dn   = 1'b0;
    step_raw  = edit_q;

    if (!cursor_ok) cursor_d = CURSOR_RESET;

    case (state_q)
      ST_EDIT: begin
        if (press[4]) begin
          out_d   = edit_q;
          valid_d = 1'b1;
          state_d = ST_COMMIT;
        end else if (press[3]) begin
          step_up = 1'b1;
        end else if (press[2]) begin
          step_dn = 1'b1;
        end else if (press[1]) begin
          if (cursor_ok) cursor_d = {cursor_q[2:0], cursor_q[3]};
        end else if (press[0]) begin
          if (cursor_ok) cursor_d = {cursor_q[0], cursor_q[3:1]};
        end else if ((REPEAT_CYCLES != 0) && (held_up || held_dn)) begin
          // Counter runs only on quiet hold cycles; any press leaves it at 0.
          if (rpt_cnt_q == CNT_LAST) begin
            step_up = held_up;
            step_dn = !held_up;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        if (valid_q && outReady) begin
          valid_d = 1'b0;
          state_d = ST_EDIT;
        end
      end
      default: state_d = ST_EDIT;
    endcase

    if (step_up || step_dn) begin
      step_raw = step_up ? (edit_q + place) : (edit_q - place);
`ifdef DIGIT_CARRY_EN
      edit_d = step_raw;
`else
      // Nothing below the selected nibble is touched, so the masked sum wraps it mod 16.
      edit_d = (step_raw & nibble_mask(place)) | (edit_q & ~nibble_mask(place));
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_EDIT;
      prev_q    <= '0;
      cursor_q  <= CURSOR_RESET;
      edit_q    <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      rpt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      cursor_q  <= cursor_d;
      edit_q    <= edit_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign cursor    = cursor_q;
  assign editValue = edit_q;
  assign outValue  = out_q;
  assign outValid  = valid_q;
  assign dbg_state = state_q;

endmodule

// File: doc/digit_entry_ctrl.md
DIGIT_ENTRY_CTRL -- requirements
Module: digit_entry_ctrl

Interface
REQ-001 The block SHALL run on one clock, with a synchronous, active-high reset.
REQ-002 Parameter REPEAT_CYCLES, default 25000000: number of cycles that Up or Down must be held before each auto-repeat step; 0 disables auto-repeat.
REQ-003 CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 btnLeft, btnRight, btnUp, btnDown, btnEnter  input  1 each  debounced button levels, high while pressed.
REQ-006 cursor  output  4  one-hot selected digit; bit 0 is the least significant nibble.
REQ-007 editValue  output  16  hex value being edited.
REQ-008 outValue  output  16  committed value.
REQ-009 outValid  output  1  committed value available.
REQ-010 outReady  input  1  consumer accepts outValue.

Function
REQ-011 Each button SHALL be edge-detected: press = level AND NOT previous-cycle level; the previous-level registers SHALL reset to 0.
REQ-012 At most one action SHALL occur per cycle. Priority: Enter > Up > Down > Left > Right. Lower-priority presses in the same cycle SHALL be discarded, not queued.
REQ-013 The FSM SHALL have two states.
- EDIT is the reset state and accepts all actions.
- COMMIT is entered on an Enter press; it ignores all buttons.
REQ-014 Enter in EDIT SHALL load outValue <= editValue and set outValid the next cycle.
REQ-015 In COMMIT, outValid && outReady SHALL clear outValid and return to EDIT on the same edge. outValue SHALL hold while outValid=1.
REQ-016 Left SHALL rotate the cursor toward the MSB, wrapping 1000->0001. Right SHALL rotate toward the LSB, wrapping 0001->1000.
REQ-017 Up/Down SHALL add/subtract the place value at the cursor. Place value = 16'h0001, 16'h0010, 16'h0100, 16'h1000 for cursor 0001, 0010, 0100, 1000.
REQ-018 Without carry (see REQ-028), only the selected nibble SHALL change, modulo 16: F+1 -> 0 and 0-1 -> F; the other nibbles are unchanged.
REQ-019 Auto-repeat: while Up (or Down) stays high in EDIT, a counter SHALL count from the press edge. Each time it reaches REPEAT_CYCLES it SHALL issue one further step and restart.
REQ-020 The repeat counter SHALL clear on release, on any other press, or on entering COMMIT.
REQ-021 If the cursor is ever not one-hot, it SHALL be forced to 0001 on the next edge, and Up/Down SHALL act as place value 0 (no change) in that cycle.
REQ-022 Latency: all outputs SHALL update on the clock edge following the press edge.

Reset
REQ-023 On RESET=1 at a clock edge, the block SHALL set cursor=4'b0001, editValue=16'h0000, outValue=16'h0000 and outValid=0. The FSM SHALL return to EDIT, and the repeat counter and previous-level registers SHALL clear.
REQ-024 Reset during COMMIT SHALL drop outValid on that edge, regardless of outReady.
REQ-025 RESET SHALL take priority over every simultaneous button or handshake event.

Configuration
REQ-026 The macro DIGIT_CARRY_EN SHALL select the Up/Down arithmetic.
REQ-027 With DIGIT_CARRY_EN defined, Up/Down SHALL perform a full 16-bit add/subtract of the place value, wrapping modulo 2^16. Example: 16'h00F0 Up at cursor 0010 -> 16'h0100.
REQ-028 Without DIGIT_CARRY_EN, the per-nibble wrap of REQ-018 SHALL apply.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state encoding (EDIT, COMMIT);
- the reset cursor constant 4'b0001;
- the place-value constants 16'h0001, 16'h0010, 16'h0100 and 16'h1000.
REQ-030 One sub-module, cursor_place_decode, SHALL map the 4-bit one-hot cursor to its 16-bit place value, outputting 0 for non-one-hot input. Everything else SHALL be inline.

Verification
REQ-031 The bench SHALL cover this directed scenario: reset, then Up pulsed 3 times -> editValue=16'h0003, cursor=0001.
REQ-032 The bench SHALL cover this directed scenario: Left x4 from reset -> cursor 0010, 0100, 1000, 0001; Right once from 0001 -> 1000.
REQ-033 The bench SHALL cover this directed scenario: editValue=16'h000F at cursor 0001, then Up -> 16'h0000 without the macro, 16'h0010 with DIGIT_CARRY_EN.
REQ-034 The bench SHALL cover this directed scenario: Enter with editValue=16'h1234 and outReady=0 for 5 cycles -> outValid=1 and outValue=16'h1234 held; Up presses ignored; outReady=1 -> outValid=0 next cycle, back in EDIT.
REQ-035 The bench SHALL cover this directed scenario: Enter and Up pressed in the same cycle -> commit only, editValue unchanged; RESET asserted in COMMIT -> outValid=0 next edge.
REQ-036 The bench SHALL cover this directed scenario: REPEAT_CYCLES=4, Up held 13 cycles from 16'h0000 -> editValue=16'h0004 (1 edge step + 3 repeats).
